// File: rtl/gnss_uart_rx.sv
// gnss_uart_rx: 8N1 UART receiver for the GNSS serial line.
// Recovers bytes from the asynchronous rx line with 3-sample majority voting
// around mid-bit, rejects false start bits and drops badly framed bytes.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle, baud counter parked at 0, waiting for falling edge
// S_START | confirming start bit at mid-bit (1 -> false start, back to idle)
// S_DATA  | shifting 8 data bits in LSB first
// S_STOP  | checking stop bit; leaves half a bit early for back-to-back frames
module gnss_uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int MID          = BAUD_CNT_MAX / 2;
  localparam int CW           = $clog2(BAUD_CNT_MAX);

  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_M1   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(MID);
  localparam logic [CW-1:0] CNT_P1   = CW'(MID + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [1:0]      r_rst_sync;
  logic            w_rst_n;
  logic            r_rx_s1;
  logic            r_rx_s2;
  logic            r_rx_s3;
  logic [CW-1:0]   r_baud_cnt;
  logic [3:0]      r_bit_cnt;
  logic [1:0]      r_samp;
  logic [7:0]      r_shift;
  logic [7:0]      r_po_data;
  logic            r_po_flag;
  logic            r_frame_err;
  logic            w_start_edge;
  logic            w_decide;
  logic            w_bit;
  logic            w_shift;
  logic            w_bit_clr;
  logic            w_load;
  logic            w_ferr;

  assign po_data   = r_po_data;
  assign po_flag   = r_po_flag;
  assign frame_err = r_frame_err;

  // Reset is applied immediately but released in step with sys_clk.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Two flops against metastability, a third only for falling-edge detection.
  always_ff @(posedge sys_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  assign w_start_edge = r_rx_s3 & ~r_rx_s2;
  assign w_decide     = (r_state != S_IDLE) && (r_baud_cnt == CNT_P1);
  // Majority of the samples at MID-1, MID and the live one at MID+1.
  assign w_bit        = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rx_s2) |
                        (r_samp[1] & r_rx_s2);

  // Bit-period counter, free-running while a frame is in progress.
  always_ff @(posedge sys_clk or negedge w_rst_n) begin
    if (!w_rst_n)                  r_baud_cnt <= '0;
    else if (r_state == S_IDLE)    r_baud_cnt <= '0;
    else if (r_baud_cnt == CNT_LAST) r_baud_cnt <= '0;
    else                           r_baud_cnt <= r_baud_cnt + 1'b1;
  end

  // Capture the first two of the three mid-bit samples.
  always_ff @(posedge sys_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_samp <= 2'b11;
    end else if (r_state != S_IDLE) begin
      if (r_baud_cnt == CNT_M1)  r_samp[0] <= r_rx_s2;
      if (r_baud_cnt == CNT_MID) r_samp[1] <= r_rx_s2;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // FSM next-state and per-decision control strobes.
  always_comb begin
    w_state_next = r_state;
    w_shift      = 1'b0;
    w_bit_clr    = 1'b0;
    w_load       = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) w_state_next = S_START;
      end
      S_START: begin
        if (w_decide) begin
          if (!w_bit) begin
            w_state_next = S_DATA;
            w_bit_clr    = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_decide) w_shift = 1'b1;
        if ((r_bit_cnt == 4'd8) && (r_baud_cnt == CNT_LAST)) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_decide) begin
          w_state_next = S_IDLE;
          if (w_bit) w_load = 1'b1;
          else       w_ferr = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Data bit counter and LSB-first shift register.
  always_ff @(posedge sys_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
    end else if (w_bit_clr) begin
      r_bit_cnt <= 4'd0;
    end else if (w_shift) begin
      r_bit_cnt <= r_bit_cnt + 4'd1;
      r_shift   <= {w_bit, r_shift[7:1]};
    end
  end

  // Output strobes and held byte; po_data only moves together with po_flag.
  always_ff @(posedge sys_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_po_data   <= 8'h00;
      r_po_flag   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_po_flag   <= w_load;
      r_frame_err <= w_ferr;
      if (w_load) r_po_data <= r_shift;
    end
  end

endmodule

// File: tb/tb_gnss_uart_rx.sv
// Directed testbench for gnss_uart_rx, run at 32 clocks per bit.
module tb_gnss_uart_rx;

  localparam int M   = 32;
  localparam int MID = M / 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         n_flag = 0;
  int         n_ferr = 0;
  int         n_both = 0;
  int         n_wide = 0;
  int         n_bad_change = 0;
  logic [7:0] rx_log [0:31];
  logic       prev_flag = 1'b0;
  logic       prev_ferr = 1'b0;
  logic       prev_rst_n = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       lat_armed = 1'b0;
  int         t_start = 0;
  int         lat = 0;

  gnss_uart_rx #(
    .CLK_FREQ(3_200_000),
    .UART_BPS(100_000)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .rx       (rx),
    .po_data  (po_data),
    .po_flag  (po_flag),
    .frame_err(frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge sys_clk) begin
    if (po_flag) begin
      rx_log[n_flag[4:0]] = po_data;
      n_flag = n_flag + 1;
      if (lat_armed) begin
        lat = cyc - t_start;
        lat_armed = 1'b0;
      end
    end
    if (frame_err) n_ferr = n_ferr + 1;
    if (po_flag && frame_err) n_both = n_both + 1;
    if ((po_flag && prev_flag) || (frame_err && prev_ferr)) n_wide = n_wide + 1;
    if (sys_rst_n && prev_rst_n && !po_flag && (po_data !== prev_data))
      n_bad_change = n_bad_change + 1;
    prev_flag  = po_flag;
    prev_ferr  = frame_err;
    prev_rst_n = sys_rst_n;
    prev_data  = po_data;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // glitch: frame bit index that gets a 1-cycle inversion at mid-bit (-1 none)
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      if (i == glitch) begin
        wait_cyc(M / 2);
        rx = ~f[i];
        wait_cyc(1);
        rx = f[i];
        wait_cyc(M - M / 2 - 1);
      end else begin
        wait_cyc(M);
      end
    end
    rx = 1'b1;
  endtask

  initial begin
    logic [7:0] gnrmc [0:5];
    logic [9:0] fa5;
    gnrmc[0] = 8'h24; gnrmc[1] = 8'h47; gnrmc[2] = 8'h4E;
    gnrmc[3] = 8'h52; gnrmc[4] = 8'h4D; gnrmc[5] = 8'h43;

    wait_cyc(5);
    check("rst_po_data", {24'd0, po_data}, 32'h00);
    check("rst_po_flag", {31'd0, po_flag}, 32'h0);
    check("rst_frame_err", {31'd0, frame_err}, 32'h0);
    sys_rst_n = 1'b1;
    wait_cyc(5);

    // single '$'
    t_start = cyc;
    lat_armed = 1'b1;
    send_frame(8'h24, 1'b1, -1);
    wait_cyc(2 * M);
    check("t1_nflag", n_flag, 1);
    check("t1_data", {24'd0, rx_log[0]}, 32'h24);
    check("t1_nferr", n_ferr, 0);
    check("t1_latency_in_window", {31'd0, (lat >= 9*M + MID + 4) && (lat <= 9*M + MID + 6)}, 32'h1);

    // "$GNRMC" back-to-back
    for (int i = 0; i < 6; i++) send_frame(gnrmc[i], 1'b1, -1);
    wait_cyc(2 * M);
    check("t2_nflag", n_flag, 7);
    for (int i = 0; i < 6; i++)
      check($sformatf("t2_byte%0d", i), {24'd0, rx_log[i+1]}, {24'd0, gnrmc[i]});

    // short low pulse: false start
    rx = 1'b0;
    wait_cyc(5);
    rx = 1'b1;
    wait_cyc(2 * M);
    check("t3_nflag_false_start", n_flag, 7);
    check("t3_nferr_false_start", n_ferr, 0);
    send_frame(8'h2A, 1'b1, -1);
    wait_cyc(2 * M);
    check("t3_nflag", n_flag, 8);
    check("t3_data", {24'd0, rx_log[7]}, 32'h2A);

    // bad stop bit
    send_frame(8'h31, 1'b0, -1);
    wait_cyc(2 * M);
    check("t4_nferr", n_ferr, 1);
    check("t4_nflag", n_flag, 8);
    check("t4_po_data_held", {24'd0, po_data}, 32'h2A);

    // glitch in middle of data bit 3 (frame bit 4)
    send_frame(8'h55, 1'b1, 4);
    wait_cyc(2 * M);
    check("t5_nflag", n_flag, 9);
    check("t5_po_data", {24'd0, po_data}, 32'h55);

    // reset during bit 4 of 0xA5
    fa5 = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = fa5[i];
      wait_cyc(M);
    end
    rx = fa5[5];
    wait_cyc(M / 2);
    sys_rst_n = 1'b0;
    rx = 1'b1;
    wait_cyc(3);
    check("t6_rst_po_data", {24'd0, po_data}, 32'h00);
    check("t6_rst_po_flag", {31'd0, po_flag}, 32'h0);
    check("t6_rst_frame_err", {31'd0, frame_err}, 32'h0);
    wait_cyc(10);
    sys_rst_n = 1'b1;
    wait_cyc(2 * M);
    check("t6_no_strobe_after_rst", n_flag + n_ferr, 10);
    send_frame(8'h5A, 1'b1, -1);
    wait_cyc(2 * M);
    check("t6_nflag", n_flag, 10);
    check("t6_data", {24'd0, rx_log[9]}, 32'h5A);
    check("t6_po_data", {24'd0, po_data}, 32'h5A);

    // line break: one frame error, then silence while low
    rx = 1'b0;
    wait_cyc(25 * M);
    check("t7_break_nferr", n_ferr, 2);
    rx = 1'b1;
    wait_cyc(2 * M);
    check("t7_nferr_after", n_ferr, 2);
    check("t7_nflag", n_flag, 10);
    check("t7_po_data", {24'd0, po_data}, 32'h5A);

    check("never_both_strobes", n_both, 0);
    check("strobes_one_cycle", n_wide, 0);
    check("po_data_only_with_flag", n_bad_change, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
